// File: rtl/dec_tx_formatter.sv
// dec_tx_formatter: prints a signed 16-bit value as ASCII decimal to a UART transmitter.
// The output is an optional '-', the digits with leading zeros suppressed, and an optional CR LF.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   val, val_valid      value to print, accepted when val_valid=1 and val_ready=1
//   val_ready           high only while idle
//   tx_din, tx_wen      character and one-cycle write strobe to the transmitter
//   tx_ready            transmitter idle; a character is captured when tx_wen=1 and tx_ready=1
module dec_tx_formatter #(
  parameter bit NEWLINE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic        val_valid,
  output logic        val_ready,
  output logic [7:0]  tx_din,
  output logic        tx_wen,
  input  logic        tx_ready
);

  localparam int unsigned MagW   = 17;
  localparam int unsigned NumDig = 5;
  localparam int unsigned PosW   = 3;

  typedef enum logic [1:0] {IDLE, CONV, SEND, GAP} state_e;

  // Character positions: 0 sign, 1..5 digits (MSD first), 6 CR, 7 LF
  localparam logic [PosW-1:0] PosCr = 3'd6;

  state_e                     state_q, state_d;
  logic                       neg_q, neg_d;
  logic [MagW-1:0]            mag_q, mag_d;
  logic [NumDig-1:0][3:0]     dig_q, dig_d;
  logic [2:0]                 idx_q, idx_d;
  logic [PosW-1:0]            pos_q, pos_d;
  logic                       last_q, last_d;
  logic [7:0]                 din_q, din_d;

  logic [7:0]                 pos_valid;
  logic [PosW-1:0]            first_pos;
  logic [PosW-1:0]            next_pos;
  logic                       next_found;
  logic [MagW-1:0]            weight;

  // Decimal weight for the digit currently being extracted
  function automatic logic [MagW-1:0] weight_of(input logic [2:0] idx);
    case (idx)
      3'd0:    weight_of = 17'd10000;
      3'd1:    weight_of = 17'd1000;
      3'd2:    weight_of = 17'd100;
      3'd3:    weight_of = 17'd10;
      default: weight_of = 17'd1;
    endcase
  endfunction

  // ASCII code for a character position
  function automatic logic [7:0] char_at(input logic [PosW-1:0] p,
                                         input logic [NumDig-1:0][3:0] d);
    case (p)
      3'd0:    char_at = 8'h2D;
      PosCr:   char_at = 8'h0D;
      3'd7:    char_at = 8'h0A;
      default: char_at = 8'h30 | {4'h0, d[PosW'(p - 3'd1)]};
    endcase
  endfunction

  // Which positions are emitted; the units digit is always printed so 0 gives "0"
  always_comb begin
    logic seen;
    seen      = 1'b0;
    pos_valid = '0;
    pos_valid[0] = neg_q;
    for (int i = 0; i < int'(NumDig); i++) begin
      seen = seen | (dig_q[i] != 4'd0) | (i == int'(NumDig) - 1);
      pos_valid[i + 1] = seen;
    end
    pos_valid[6] = NEWLINE;
    pos_valid[7] = NEWLINE;
  end

  // First emitted position, and the next one after pos_q (descending scan keeps the lowest)
  always_comb begin
    first_pos  = 3'd5;
    next_pos   = '0;
    next_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pos_valid[i]) begin
        first_pos = PosW'(i);
      end
      if (pos_valid[i] && (i > int'(pos_q))) begin
        next_pos   = PosW'(i);
        next_found = 1'b1;
      end
    end
  end

  assign weight = weight_of(idx_q);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    last_d  = last_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (val_valid) begin
          neg_d   = val[15];
          // Sign-extend before negating so -32768 yields 32768
          mag_d   = val[15] ? (17'd0 - {val[15], val}) : {1'b0, val};
          dig_d   = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (mag_q >= weight) begin
          mag_d        = mag_q - weight;
          dig_d[idx_q] = dig_q[idx_q] + 4'd1;
        end else if (idx_q == 3'(NumDig - 1)) begin
          pos_d   = first_pos;
          din_d   = char_at(first_pos, dig_q);
          last_d  = 1'b0;
          state_d = SEND;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_d = GAP;
          if (next_found) begin
            pos_d = next_pos;
            din_d = char_at(next_pos, dig_q);
          end else begin
            last_d = 1'b1;
          end
        end
      end
      GAP: begin
        // One dead cycle lets the transmitter drop tx_ready before we look again
        state_d = last_q ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      dig_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      last_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      din_q   <= din_d;
    end
  end

  assign val_ready = (state_q == IDLE);
  assign tx_din    = din_q;
  // Strobe follows tx_ready directly so no write is issued to a busy transmitter
  assign tx_wen    = (state_q == SEND) && tx_ready;

endmodule
